lut_bank: RTL and testbench
===========================

# lut_bank

Multi-output programmable look-up table: `OUTPUTS` independent truth tables share one `WIDTH`-bit input bus, so one `run_in` produces `OUTPUTS` result bits per cycle. Configuration is a flow-controlled serial bit stream with restart and completion signalling. The bank is the combinational core of the next-generation logic tile, with an optional output flip-flop selected at compile time. It replaces single-output LUT instances where several functions of the same inputs are needed.

## Interface
- `WIDTH`, 4, LUT input count; must be ≥1.
- `OUTPUTS`, 2, number of truth tables / output bits; must be ≥1.
- `DEPTH`, `1 << WIDTH`, entries per table; derived, not overridden.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  one-cycle request to (re)start loading.
- `cfg_valid`  in  1  `cfg_data` valid this cycle.
- `cfg_data`  in  1  serial configuration bit.
- `cfg_ready`  out  1  high in LOAD; a bit is accepted when `cfg_valid && cfg_ready`.
- `cfg_done`  out  1  one-cycle pulse after the last bit is accepted.
- `run`  in  1  request evaluation.
- `run_in`  in  `WIDTH`  LUT select inputs.
- `run_out`  out  `OUTPUTS`  bit k = table k indexed by `run_in`.
- `run_valid`  out  1  `run_out` meaningful this cycle.

## Operation
- Storage: `OUTPUTS*DEPTH` bits. The bit counter `cnt` is `$clog2(OUTPUTS*DEPTH)` wide, minimum 1.
- Stream order: accepted bit n writes table `n / DEPTH`, entry `n % DEPTH`. Table 0 entry 0 is sent first.
- States: UNCFG, LOAD, IDLE, RUN. Reset → UNCFG; tables, `cnt`, and every output are 0.
- UNCFG: `run` is ignored. `cfg_start` → LOAD.
- LOAD: `cfg_ready=1`.
  - Each accept writes one bit and increments `cnt`.
  - `cfg_valid=0` stalls; nothing changes.
  - Accepting the bit at `cnt == OUTPUTS*DEPTH-1` moves to IDLE, pulses `cfg_done` next cycle, and clears `cnt`.
- `cfg_start` in LOAD aborts and restarts: `cnt←0` and the bit offered that cycle is dropped. Already-written bits keep their values until overwritten.
- IDLE: `cfg_start` → LOAD; else `run` → RUN.
- RUN: `run_valid=1` and `run_out[k] = table_k[run_in]`.
  - `cfg_start` → LOAD. `cfg_start` has priority over `run` in every state.
  - Else `!run` → IDLE.
- Outside RUN, `run_out` is all zeros and `run_valid=0`. Outputs are never X.
- Reset asserted mid-LOAD or mid-RUN returns asynchronously to the reset condition. A partially loaded configuration is discarded.

## Timing
- `cfg_start` at edge t → `cfg_ready=1` from t+1.
- Minimum load time: `OUTPUTS*DEPTH` cycles of continuous `cfg_valid`.
- Last accept at edge t → `cfg_done=1` during cycle t+1 only; IDLE from t+1.
- `run` sampled at edge t in IDLE → RUN, `run_valid=1` from t+1.
- Combinational build: `run_out` follows `run_in` in the same cycle (0-cycle latency) while in RUN.
- `run` low at edge t → `run_valid=0` from t+1.

## Configuration
- Macro: `LUT_BANK_REG_OUT_EN`.
- Defined:
  - `run_out` and `run_valid` are registered. At each edge, `run_out <= (state==RUN) ? lookup(run_in) : 0` and `run_valid <= (state==RUN)`.
  - Latency from `run_in` to `run_out` is 1 cycle, and all RUN timings above shift by +1.
  - Both registers reset to 0 asynchronously.
- Undefined: the combinational path described above.

## Test plan
- Reset, then `run=1` for 5 cycles with no config → stays in UNCFG, `run_valid=0`, `run_out=0`, `cfg_ready=0`.
- WIDTH=2, OUTPUTS=2; load stream 0,0,0,1 then 0,1,1,0 (table0=AND, table1=XOR) → `cfg_done` pulses once. In RUN, `run_in`=0,1,2,3 gives `run_out`=2'b00, 2'b10, 2'b10, 2'b01 (bit0=AND, bit1=XOR).
- The same load with `cfg_valid` deasserted for 3 cycles after bits 2 and 5 → identical tables; `cfg_done` is delayed by 6 cycles.
- Assert `cfg_start` after 5 accepted bits, then send a full 8-bit stream of all ones → both tables are all ones and `run_out=2'b11` for every `run_in`.
- In RUN, assert `cfg_start` and `run` together → LOAD next cycle, `run_valid=0`. Assert `rst_n=0` mid-load → tables read 0 after reconfiguring with zeros.
- With `LUT_BANK_REG_OUT_EN` defined, rerun the AND/XOR scenario → each result appears exactly one cycle after its `run_in`.

Source files
------------

// File: rtl/lut_bank.sv
// lut_bank
//   Multi-output programmable look-up table. OUTPUTS independent truth
//   tables of DEPTH = 2**WIDTH entries share one WIDTH-bit select bus, so a
//   single run_in yields OUTPUTS result bits. Tables are filled from a
//   flow-controlled serial stream (table 0 entry 0 first), with restart
//   (cfg_start) and completion (cfg_done) signalling.
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_start  in   one-cycle request to (re)start loading
//   cfg_valid  in   cfg_data valid this cycle
//   cfg_data   in   serial configuration bit
//   cfg_ready  out  high while loading; bit accepted on cfg_valid && cfg_ready
//   cfg_done   out  one-cycle pulse after the last bit is accepted
//   run        in   request evaluation
//   run_in     in   [WIDTH-1:0] LUT select inputs
//   run_out    out  [OUTPUTS-1:0] bit k = table k indexed by run_in
//   run_valid  out  run_out meaningful this cycle
//
// Compile-time option
//   LUT_BANK_REG_OUT_EN : when defined, run_out/run_valid are registered
//   (one extra cycle of latency); otherwise they are combinational.

module lut_bank #(
  parameter int WIDTH   = 4,
  parameter int OUTPUTS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  input  logic               cfg_data,
  output logic               cfg_ready,
  output logic               cfg_done,
  input  logic               run,
  input  logic [WIDTH-1:0]   run_in,
  output logic [OUTPUTS-1:0] run_out,
  output logic               run_valid
);

  localparam int DEPTH = 1 << WIDTH;
  localparam int TOTAL = OUTPUTS * DEPTH;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [1:0] S_UNCFG = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_IDLE  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [TOTAL-1:0]   mem_q;
  logic               accept;
  logic               lastBit;
  logic [OUTPUTS-1:0] lookup;

  // A restart request in LOAD drops the bit offered in the same cycle.
  assign accept  = (state_q == S_LOAD) && cfg_valid && !cfg_start;
  assign lastBit = (cnt_q == CW'(TOTAL - 1));

  // cfg_start has priority over run in every state and always rewinds cnt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (cfg_start) begin
      state_d = S_LOAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (lastBit) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_IDLE:  if (run)  state_d = S_RUN;
        S_RUN:   if (!run) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_UNCFG;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Stream bit n lands at flat index n, i.e. table n/DEPTH, entry n%DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (accept) begin
      mem_q[cnt_q] <= cfg_data;
    end
  end

  for (genvar k = 0; k < OUTPUTS; k++) begin : g_tbl
    logic [DEPTH-1:0] tbl;
    assign tbl       = mem_q[k*DEPTH +: DEPTH];
    assign lookup[k] = tbl[run_in];
  end

  assign cfg_ready = (state_q == S_LOAD);
  assign cfg_done  = done_q;

`ifdef LUT_BANK_REG_OUT_EN
  logic [OUTPUTS-1:0] runOut_q;
  logic               runValid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runOut_q   <= '0;
      runValid_q <= 1'b0;
    end else begin
      runOut_q   <= (state_q == S_RUN) ? lookup : '0;
      runValid_q <= (state_q == S_RUN);
    end
  end

  assign run_out   = runOut_q;
  assign run_valid = runValid_q;
`else
  assign run_out   = (state_q == S_RUN) ? lookup : '0;
  assign run_valid = (state_q == S_RUN);
`endif

endmodule

// File: tb/tb_lut_bank.sv
// tb_lut_bank
//   Randomised and directed stimulus for lut_bank (WIDTH=2, OUTPUTS=2).
//   The reference model keeps the tables as plain arrays filled by stream
//   position and tracks only whether the bank is loading or evaluating.
//   Expected lookups are queued when issued and a monitor compares them
//   whenever the DUT flags run_valid. Works with or without
//   LUT_BANK_REG_OUT_EN.

module tb_lut_bank;

  localparam int WIDTH   = 2;
  localparam int OUTPUTS = 2;
  localparam int DEPTH   = 1 << WIDTH;
  localparam int TOTAL   = OUTPUTS * DEPTH;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_start, cfg_valid, cfg_data;
  logic               cfg_ready, cfg_done;
  logic               run;
  logic [WIDTH-1:0]   run_in;
  logic [OUTPUTS-1:0] run_out;
  logic               run_valid;

  always #5 clk = ~clk;

  lut_bank #(.WIDTH(WIDTH), .OUTPUTS(OUTPUTS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .run       (run),
    .run_in    (run_in),
    .run_out   (run_out),
    .run_valid (run_valid)
  );

  int checks = 0;
  int passes = 0;

  logic [OUTPUTS-1:0] sbQueue[$];

  bit modelTbl [OUTPUTS][DEPTH];
  int nextIdx    = 0;
  bit inLoad     = 0;
  bit configured = 0;
  bit running    = 0;
  bit doneFlag   = 0;

  int cycleNum      = 0;
  int donePulses    = 0;
  int lastDoneCycle = 0;

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endfunction

  function automatic logic [OUTPUTS-1:0] modelLookup(input logic [WIDTH-1:0] sel);
    logic [OUTPUTS-1:0] res;
    for (int k = 0; k < OUTPUTS; k++) res[k] = modelTbl[k][int'(sel)];
    return res;
  endfunction

  always @(posedge clk) cycleNum++;

  // Monitor: pops one expected result per valid output, else demands zeros.
  always @(negedge clk) begin
    logic [OUTPUTS-1:0] expV;
    if (cfg_done === 1'b1) begin
      donePulses++;
      lastDoneCycle = cycleNum;
    end
    if (run_valid === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected run_valid", 32'(1), 32'(0));
      end else begin
        expV = sbQueue.pop_front();
        checkOutput("run_out", 32'(run_out), 32'(expV));
      end
    end else begin
      checkOutput("run_out idle zero", 32'(run_out), 32'(0));
    end
  end

  // Drive one cycle of inputs; queue the lookup if the bank evaluates now.
  task automatic applyStimulus(input logic start, input logic valid, input logic data,
                               input logic runReq, input logic [WIDTH-1:0] sel);
    cfg_start = start;
    cfg_valid = valid;
    cfg_data  = data;
    run       = runReq;
    run_in    = sel;
    if (running) sbQueue.push_back(modelLookup(sel));
    @(negedge clk);
    checkOutput("cfg_ready", 32'(cfg_ready), 32'(inLoad));
    checkOutput("cfg_done", 32'(cfg_done), 32'(doneFlag));
  endtask

  // Let the edge happen and apply the same inputs to the model.
  task automatic advance();
    @(posedge clk);
    #1;
    doneFlag = 0;
    if (cfg_start) begin
      inLoad  = 1;
      nextIdx = 0;
      running = 0;
    end else if (inLoad) begin
      if (cfg_valid) begin
        modelTbl[nextIdx / DEPTH][nextIdx % DEPTH] = cfg_data;
        nextIdx++;
        if (nextIdx == TOTAL) begin
          nextIdx    = 0;
          inLoad     = 0;
          configured = 1;
          doneFlag   = 1;
        end
      end
    end else if (configured) begin
      running = run;
    end
  endtask

  task automatic cfgStart(input logic offerValid);
    applyStimulus(1'b1, offerValid, 1'($urandom), 1'($urandom), WIDTH'($urandom));
    advance();
  endtask

  task automatic loadStream(input logic [63:0] bits, input int len, input int stallA,
                            input int stallB, input int stallLen, output int latency);
    int t0;
    t0 = cycleNum;
    for (int n = 0; n < len; n++) begin
      applyStimulus(1'b0, 1'b1, bits[n], 1'($urandom), WIDTH'($urandom));
      advance();
      if (n == stallA || n == stallB) begin
        for (int s = 0; s < stallLen; s++) begin
          applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), WIDTH'($urandom));
          advance();
        end
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, WIDTH'($urandom));
    advance();
    latency = lastDoneCycle - t0;
  endtask

  task automatic runPhase(input int n, input bit directed);
    logic [WIDTH-1:0] sel;
    for (int i = 0; i < n; i++) begin
      sel = directed ? WIDTH'(i + DEPTH - 1) : WIDTH'($urandom);
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'b1, sel);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, WIDTH'($urandom));
      advance();
    end
    checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'(0));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset cfg_ready", 32'(cfg_ready), 32'(0));
    checkOutput("reset cfg_done", 32'(cfg_done), 32'(0));
    checkOutput("reset run_valid", 32'(run_valid), 32'(0));
    checkOutput("reset run_out", 32'(run_out), 32'(0));
    for (int k = 0; k < OUTPUTS; k++)
      for (int e = 0; e < DEPTH; e++) modelTbl[k][e] = 0;
    nextIdx = 0; inLoad = 0; configured = 0; running = 0; doneFlag = 0;
    sbQueue.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat1, lat2, latX, d0;
    rst_n = 1'b0; cfg_start = 0; cfg_valid = 0; cfg_data = 0; run = 0; run_in = '0;
    @(posedge clk);
    #1;
    doReset();

    // Unconfigured bank ignores run.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'($urandom));
      advance();
    end

    // AND / XOR tables, contiguous stream.
    cfgStart(1'b0);
    d0 = donePulses;
    loadStream(64'h68, TOTAL, -1, -1, 0, lat1);
    checkOutput("done pulses and/xor", 32'(donePulses - d0), 32'(1));
    runPhase(DEPTH + 1, 1'b1);

    // Same stream with two 3-cycle stalls.
    cfgStart(1'b0);
    d0 = donePulses;
    loadStream(64'h68, TOTAL, 2, 5, 3, lat2);
    checkOutput("done pulses stalled", 32'(donePulses - d0), 32'(1));
    checkOutput("stall delay", 32'(lat2 - lat1), 32'(6));
    runPhase(DEPTH + 1, 1'b1);

    // Abort after 5 bits, restart (offered bit dropped), load all ones.
    cfgStart(1'b0);
    loadStream(64'h15, 5, -1, -1, 0, latX);
    cfgStart(1'b1);
    d0 = donePulses;
    loadStream(64'hFF, TOTAL, -1, -1, 0, latX);
    checkOutput("done pulses after abort", 32'(donePulses - d0), 32'(1));
    runPhase(10, 1'b0);

    // cfg_start together with run while evaluating.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'($urandom));
      advance();
    end
    applyStimulus(1'b1, 1'b1, 1'($urandom), 1'b1, WIDTH'($urandom));
    advance();
    loadStream(64'($urandom), TOTAL, -1, -1, 0, latX);
    runPhase(8, 1'b0);

    // Reset in the middle of a load, then reload with zeros.
    cfgStart(1'b0);
    loadStream(64'h7, 3, -1, -1, 0, latX);
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, WIDTH'($urandom));
      advance();
    end
    cfgStart(1'b0);
    loadStream(64'h0, TOTAL, -1, -1, 0, latX);
    runPhase(DEPTH + 1, 1'b1);

    // Random configurations with random stalls.
    for (int r = 0; r < 5; r++) begin
      cfgStart(1'($urandom));
      loadStream(64'($urandom), TOTAL, $urandom_range(TOTAL - 1), $urandom_range(TOTAL - 1),
                 $urandom_range(2), latX);
      runPhase($urandom_range(12, 4), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
